keypad_scan: RTL
================

Name: keypad_scan

Overview:
- Front-end scanner for the 4x4 matrix keypad; sits directly upstream of the keyboard/password logic.
- Drives the column lines and samples the row lines.
- Debounces whole scan frames and publishes a 16-bit debounced key map plus single-cycle press/release events with a 4-bit key code.
- Downstream logic consumes key_valid/key_code for digit entry and key_state for the per-key LED map.

Parameters:
- SCAN_DIV, 100000, clk cycles per column dwell (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full frames required before commit; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- row  input  4  keypad rows, active low (pulled up); asynchronous to clk
- col  output  4  keypad columns, one-hot active low
- key_state  output  16  debounced map, 1 = pressed; bit index = col_idx*4 + row_idx
- key_valid  output  1  one-cycle pulse on new press
- key_code  output  4  code of the reported key; held until the next key_valid
- key_held  output  1  high while any debounced key is down
- key_release  output  1  one-cycle pulse when all keys are released

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All outputs are registered.
- Reset values: col=4'b1110, key_state=0, key_valid=0, key_code=0, key_held=0, key_release=0. Divider, column index, frame buffers and debounce counter are cleared; FSM goes to IDLE.
- Reset asserted mid-press: all outputs return to their reset values on the next edge. A key still held after reset is reported as a fresh press once debounced.
- Row sync: row passes through a 2-FF synchronizer before any use.
- Divider: counts 0..SCAN_DIV-1 and emits tick when count == SCAN_DIV-1.
- Column sequence: col_idx 0..3 maps to col = 1110, 1101, 1011, 0111.
- On tick:
  - Sample the synchronized row for the current col_idx: frame_raw[col_idx*4+r] <= ~row_sync[r].
  - Then advance col_idx, wrapping 3 -> 0.
- Frame end: the tick with col_idx==3 completes a frame, one every 4*SCAN_DIV cycles.
- Debounce, evaluated at each frame end:
  - If the new frame equals the previous frame, stable_cnt = min(stable_cnt+1, DEBOUNCE_SCANS). Otherwise stable_cnt = 1 and the previous frame is replaced.
  - When stable_cnt reaches DEBOUNCE_SCANS, key_state <= frame in the same edge.
  - Once saturated, further identical frames cause no change.
  - A bouncing input that never holds DEBOUNCE_SCANS identical frames never commits.
- Key code map:
  - col0 rows 0..3 = 1, 4, 7, *
  - col1 = 2, 5, 8, 0
  - col2 = 3, 6, 9, #
  - col3 = A, B, C, D
  - Codes: digits 0-9 = 4'd0-4'd9, A-D = 4'd10-4'd13, * = 4'd14, # = 4'd15.
- FSM, evaluated on the committed key_state:
  - IDLE: if the new key_state != 0, go to HELD. Pulse key_valid for one cycle on the same edge key_state updates. key_code = code of the lowest set bit index. key_held <= 1.
  - HELD: additional keys pressed (rollover) produce no event and leave key_code unchanged. If the new key_state == 0, pulse key_release for one cycle, key_held <= 0, go to IDLE.
  - Partial release then re-press while any key stays down: no event.
- Latency: a clean press stable from a frame start produces key_valid at the end of frame DEBOUNCE_SCANS, i.e. <= (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles after the row edge, including synchronizer delay and frame alignment.
- key_valid and key_release are never high in the same cycle.

Test Plan:
- Reset: SCAN_DIV=4, DEBOUNCE_SCANS=2. Hold reset 3 cycles -> col=1110, all other outputs 0. Release -> col steps 1110, 1101, 1011, 0111 every 4 cycles, then wraps.
- Single press of key 5: row[1] low whenever col=1101, held 4 frames -> exactly one key_valid pulse with key_code=4'd5, key_state=16'h0020, key_held=1, at the end of the 2nd stable frame. Release -> key_release one pulse 2 frames later, key_state=0.
- Bounce: key 9 (col2,row2) toggled pressed/released on alternate frames for 10 frames -> key_valid never asserts; key_state stays 0.
- Simultaneous press of 7 (idx 2) and 0 (idx 7) in the same frame -> key_state=16'h0084, one key_valid with key_code=4'd7.
- Rollover: hold A (idx 12), then add # (idx 11) -> no second key_valid; key_state=16'h1800. Release both -> one key_release.
- Reset mid-hold: while D (idx 15) is held with key_held=1, pulse reset -> all outputs 0 the next cycle. D still held -> new key_valid with key_code=4'd13 after 2 stable frames.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one-hot active-low columns, samples rows,
// debounces whole scan frames and reports press/release events with a key code.
module keypad_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] key_state,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic        key_release
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  // Key code indexed by bit position col_idx*4 + row_idx.
  localparam logic [3:0] CODE_MAP [16] = '{
    4'd1,  4'd4,  4'd7,  4'd14,
    4'd2,  4'd5,  4'd8,  4'd0,
    4'd3,  4'd6,  4'd9,  4'd15,
    4'd10, 4'd11, 4'd12, 4'd13
  };

  typedef enum logic {IDLE, HELD} state_t;

  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick, frame_end, commit;
  logic [1:0]       col_idx, idx_next;
  logic [15:0]      frame_raw, frame_prev, frame_next;
  logic [CNT_W-1:0] stable_cnt, cnt_next;
  state_t           state;

  function automatic logic [3:0] lowest_code(input logic [15:0] map);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--)
      if (map[i]) idx = 4'(i);
    return CODE_MAP[idx];
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign tick      = (div_cnt == DIV_LAST);
  assign frame_end = tick && (col_idx == 2'd3);
  assign idx_next  = col_idx + 2'd1;

  // The frame completing on this tick still lacks column 3; splice it in here.
  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    frame_next        = frame_raw;
    frame_next[15:12] = ~row_sync;
    cnt_next          = CNT_W'(1);
    if (frame_next == frame_prev)
      cnt_next = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 1'b1;
  end

  assign commit = frame_end && (cnt_next == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      col_idx    <= 2'd0;
      col        <= 4'b1110;
      frame_raw  <= '0;
      frame_prev <= '0;
      stable_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (tick) begin
        div_cnt                         <= '0;
        frame_raw[{col_idx, 2'b00} +: 4] <= ~row_sync;
        col_idx                         <= idx_next;
        col                             <= ~(4'b0001 << idx_next);
      end
      if (frame_end) begin
        stable_cnt <= cnt_next;
        if (frame_next != frame_prev) frame_prev <= frame_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      key_state   <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (commit) begin
        key_state <= frame_next;
        case (state)
          IDLE: if (frame_next != '0) begin
            key_valid <= 1'b1;
            key_code  <= lowest_code(frame_next);
            key_held  <= 1'b1;
            state     <= HELD;
          end
          HELD: if (frame_next == '0) begin
            key_release <= 1'b1;
            key_held    <= 1'b0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
